// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart transmitter among NUM_REQ byte-stream
// requesters. Round-robin choice at frame boundaries; the winner keeps the
// transmitter until it hands over a byte flagged last.
// Optional feature macro: UART_ARB_TIMEOUT_EN (abort a stalled frame after
// TIMEOUT idle HOLD cycles and pulse frame_abort).
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                   uart_clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic [7:0]             tx_data,
    output logic                   tx_wren,
    input  logic                   tx_accept,
    output logic                   frame_abort
);

    localparam int IW = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 2) begin : g_bad_param
        $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 2");
    end

    logic [1:0]         r_state;
    logic [IW-1:0]      r_rr;
    logic [IW-1:0]      r_owner;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_busy;
    logic [7:0]         r_tx_data;
    logic               r_tx_wren;
    logic               r_last_q;

    logic [NUM_REQ-1:0] w_rot;
    logic               w_any;
    logic [IW:0]        w_sum;
    logic [IW-1:0]      w_winner;
    logic [IW:0]        w_nsum;
    logic [IW-1:0]      w_next_rr;

    // Request vector rotated so bit 0 is the requester the rr pointer favours
    assign w_rot = NUM_REQ'({req_valid, req_valid} >> r_rr);

    // Pick the first valid requester at or after the rr pointer, with wrap
    always_comb begin
        w_any    = 1'b0;
        w_sum    = '0;
        w_winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_any = 1'b1;
                w_sum = {1'b0, r_rr} + (IW+1)'(k);
                if (w_sum >= (IW+1)'(NUM_REQ)) begin
                    w_sum = w_sum - (IW+1)'(NUM_REQ);
                end
                w_winner = w_sum[IW-1:0];
            end
        end
    end

    // Pointer value that puts the current owner last in line
    always_comb begin
        w_nsum = {1'b0, r_owner} + (IW+1)'(1);
        if (w_nsum == (IW+1)'(NUM_REQ)) begin
            w_nsum = '0;
        end
        w_next_rr = w_nsum[IW-1:0];
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] r_cnt;
    logic          r_abort;
`endif

    // Arbitration state machine and transmitter-side registers
    always_ff @(posedge uart_clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_rr      <= '0;
            r_owner   <= '0;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_tx_data <= 8'h00;
            r_tx_wren <= 1'b0;
            r_last_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            r_cnt     <= '0;
            r_abort   <= 1'b0;
`endif
        end else begin
`ifdef UART_ARB_TIMEOUT_EN
            r_abort <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_owner   <= w_winner;
                        r_grant   <= NUM_REQ'(1) << w_winner;
                        r_tx_data <= req_data[{w_winner, 3'b000} +: 8];
                        r_last_q  <= req_last[w_winner];
                        r_tx_wren <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // The transmitter may stall here arbitrarily long (init delay)
                    if (tx_accept) begin
                        r_tx_wren <= 1'b0;
                        if (r_last_q) begin
                            r_state <= ST_IDLE;
                            r_grant <= '0;
                            r_busy  <= 1'b0;
                            r_rr    <= w_next_rr;
                        end else begin
                            r_state <= ST_HOLD;
`ifdef UART_ARB_TIMEOUT_EN
                            r_cnt   <= '0;
`endif
                        end
                    end
                end
                ST_HOLD: begin
                    // Frame lock: only the owner can move us back to SEND
                    if (req_valid[r_owner]) begin
                        r_tx_data <= req_data[{r_owner, 3'b000} +: 8];
                        r_last_q  <= req_last[r_owner];
                        r_tx_wren <= 1'b1;
                        r_state   <= ST_SEND;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_rr    <= w_next_rr;
                        r_abort <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
`endif
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_grant   <= '0;
                    r_busy    <= 1'b0;
                    r_tx_wren <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    assign frame_abort = r_abort;
`else
    assign frame_abort = 1'b0;
`endif

    assign req_ack = (r_state == ST_SEND && tx_accept) ? r_grant : '0;
    assign grant   = r_grant;
    assign busy    = r_busy;
    assign tx_data = r_tx_data;
    assign tx_wren = r_tx_wren;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester drivers, a transmitter model with
// programmable accept delay, and a scoreboard of expected transmitted bytes.
module tb_uart_tx_arbiter;

    localparam int NR = 4;

    logic            clk;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ack;
    logic [NR-1:0]   grant;
    logic            busy;
    logic [7:0]      tx_data;
    logic            tx_wren;
    logic            tx_accept;
    logic            frame_abort;

    uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT(16)) dut (
        .uart_clock (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ack    (req_ack),
        .grant      (grant),
        .busy       (busy),
        .tx_data    (tx_data),
        .tx_wren    (tx_wren),
        .tx_accept  (tx_accept),
        .frame_abort(frame_abort)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [1:0] r;
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] rq_mem [NR][32];
    int         rq_rd  [NR];
    int         rq_wr  [NR];
    logic [NR-1:0] ack_s;

    int         n_checks = 0;
    int         n_errors = 0;
    int         acc_delay = 1;
    int         acc_cnt = 0;
    logic       pend = 1'b0;
    logic [7:0] held = 8'h00;
    logic       post_pending = 1'b0;
    logic       post_last = 1'b0;
    logic [NR-1:0] post_grant = '0;
    int         abort_cnt = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic push_req(input int r, input logic [7:0] d, input logic l);
        rq_mem[r][rq_wr[r]] = {l, d};
        rq_wr[r]++;
    endtask

    task automatic push_exp(input int r, input logic [7:0] d, input logic l);
        exp_t e;
        e.r = 2'(r);
        e.d = d;
        e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < NR; i++) begin
            rq_rd[i] = 0;
            rq_wr[i] = 0;
        end
        exp_q.delete();
        post_pending = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk_eq("drain_done", 32'((exp_q.size() == 0) && !busy), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_hold(input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && busy && !tx_wren && !tx_accept) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk_eq("reach_hold", 32'(exp_q.size() == 0 && busy && !tx_wren), 32'd1);
    endtask

    // Requesters: pop the byte acked at the last edge, then present the next one
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (ack_s[i] && rq_rd[i] != rq_wr[i]) rq_rd[i]++;
                if (rq_rd[i] != rq_wr[i]) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = rq_mem[i][rq_rd[i]][7:0];
                    req_last[i]        = rq_mem[i][rq_rd[i]][8];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Transmitter model: pulse tx_accept acc_delay cycles after tx_wren rises
    initial begin
        tx_accept = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                pend      = 1'b0;
                tx_accept = 1'b0;
            end else if (tx_accept) begin
                tx_accept = 1'b0;
                pend      = 1'b0;
            end else if (pend) begin
                acc_cnt--;
                if (acc_cnt <= 0) tx_accept = 1'b1;
            end
        end
    end

    // Monitor and scoreboard
    initial begin
        ack_s = '0;
        forever begin
            @(negedge clk);
            ack_s = req_ack;
            if (frame_abort) abort_cnt++;
            if (!reset) begin
                if (post_pending) begin
                    post_pending = 1'b0;
                    if (post_last) begin
                        chk_eq("post_grant", 32'(grant), 32'd0);
                        chk_eq("post_busy", 32'(busy), 32'd0);
                        chk_eq("post_wren", 32'(tx_wren), 32'd0);
                    end else begin
                        chk_eq("lock_grant", 32'(grant), 32'(post_grant));
                        chk_eq("lock_busy", 32'(busy), 32'd1);
                    end
                end
                if (tx_accept) begin
                    if (exp_q.size() == 0) begin
                        chk_eq("unexpected_byte", 32'(tx_data), 32'h1ff);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk_eq("tx_data", 32'(tx_data), 32'(e.d));
                        chk_eq("grant", 32'(grant), 32'(4'b0001 << e.r));
                        chk_eq("req_ack", 32'(req_ack), 32'(4'b0001 << e.r));
                        post_pending = 1'b1;
                        post_last    = e.l;
                        post_grant   = 4'b0001 << e.r;
                    end
                end else begin
                    chk_eq("ack_quiet", 32'(req_ack), 32'd0);
                    if (pend) begin
                        chk_eq("wren_hold", 32'(tx_wren), 32'd1);
                        chk_eq("data_hold", 32'(tx_data), 32'(held));
                    end else if (tx_wren) begin
                        pend    = 1'b1;
                        acc_cnt = acc_delay;
                        held    = tx_data;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t limit=200000", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        reset = 1'b1;
        for (int i = 0; i < NR; i++) begin
            rq_rd[i] = 0;
            rq_wr[i] = 0;
        end

        // Reset values
        do_reset();
        chk_eq("rst_grant", 32'(grant), 32'd0);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_wren", 32'(tx_wren), 32'd0);
        chk_eq("rst_data", 32'(tx_data), 32'd0);
        chk_eq("rst_abort", 32'(frame_abort), 32'd0);

        // Single byte, accept 5 cycles after tx_wren
        acc_delay = 5;
        push_req(1, 8'hA5, 1'b1);
        push_exp(1, 8'hA5, 1'b1);
        @(negedge clk);
        chk_eq("lat_wren_lo", 32'(tx_wren), 32'd0);
        @(negedge clk);
        chk_eq("lat_wren_hi", 32'(tx_wren), 32'd1);
        chk_eq("lat_data", 32'(tx_data), 32'hA5);
        chk_eq("lat_grant", 32'(grant), 32'b0010);
        chk_eq("lat_busy", 32'(busy), 32'd1);
        wait_idle(100);

        // Round robin: 0,1,2,3 then 0 again (second frame queued on 0)
        do_reset();
        acc_delay = 1;
        push_req(0, 8'h10, 1'b1);
        push_req(0, 8'h50, 1'b1);
        push_req(1, 8'h21, 1'b1);
        push_req(2, 8'h32, 1'b1);
        push_req(3, 8'h43, 1'b1);
        push_exp(0, 8'h10, 1'b1);
        push_exp(1, 8'h21, 1'b1);
        push_exp(2, 8'h32, 1'b1);
        push_exp(3, 8'h43, 1'b1);
        push_exp(0, 8'h50, 1'b1);
        wait_idle(200);

        // Reset while holding a frame (rr pointer is 1 going in)
        acc_delay = 2;
        push_req(1, 8'h01, 1'b0);
        push_exp(1, 8'h01, 1'b0);
        wait_hold(100);
        do_reset();
        chk_eq("mid_rst_wren", 32'(tx_wren), 32'd0);
        chk_eq("mid_rst_grant", 32'(grant), 32'd0);
        chk_eq("mid_rst_busy", 32'(busy), 32'd0);
        push_req(3, 8'h3C, 1'b1);
        push_req(0, 8'h0C, 1'b1);
        push_exp(0, 8'h0C, 1'b1);
        push_exp(3, 8'h3C, 1'b1);
        wait_idle(100);

        // Frame lock: req 2 three-byte frame while req 0 waits
        do_reset();
        acc_delay = 3;
        push_req(2, 8'h11, 1'b0);
        push_req(2, 8'h22, 1'b0);
        push_req(2, 8'h33, 1'b1);
        push_exp(2, 8'h11, 1'b0);
        push_exp(2, 8'h22, 1'b0);
        push_exp(2, 8'h33, 1'b1);
        @(negedge clk);
        @(negedge clk);
        push_req(0, 8'h44, 1'b1);
        push_exp(0, 8'h44, 1'b1);
        wait_idle(200);

        // Transmitter init delay: tx_accept held off for 300 cycles
        acc_delay = 300;
        push_req(3, 8'h5C, 1'b1);
        push_exp(3, 8'h5C, 1'b1);
        wait_idle(400);

`ifdef UART_ARB_TIMEOUT_EN
        // Owner stalls after a non-last byte; abort after 16 HOLD cycles
        do_reset();
        acc_delay = 2;
        push_req(2, 8'hAA, 1'b0);
        push_exp(2, 8'hAA, 1'b0);
        wait_hold(100);
        push_req(1, 8'hBB, 1'b1);
        push_exp(1, 8'hBB, 1'b1);
        n = 0;
        while (!frame_abort && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_eq("abort_latency", 32'(n), 32'd16);
        @(negedge clk);
        chk_eq("abort_pulse", 32'(frame_abort), 32'd0);
        wait_idle(100);
        chk_eq("abort_count", 32'(abort_cnt), 32'd1);
`else
        n = abort_cnt;
        chk_eq("abort_never", 32'(n), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
